// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// show-ahead byte FIFO read by the core.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    input  logic       uart_rdreq,
    output logic [7:0] uart_in,
    output logic       uart_empty,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PTR_W = FIFO_AW + 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    // Counter counts down to zero, so a load of N-1 expires after exactly N cycles.
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY    = 3'd5
`endif
    } rx_state_e;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             cnt_done_c;
    logic             push_c;
    logic             ferr_c;
    logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic             overrun_q, overrun_d;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             wr_en_c;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    assign rx_s       = sync_q[1];
    assign cnt_done_c = (cnt_q == '0);

    // Receiver registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= ferr_c;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    // Receiver next-state: mid-bit sampling, byte assembly, push and error decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push_c  = 1'b0;
        ferr_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = S_START;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (cnt_done_c) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = BIT_RELOAD;
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_done_c) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = BIT_RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_done_c) begin
                    par_err_d = rx_s ^ (^shift_q);
                    cnt_d     = BIT_RELOAD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_done_c) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        ferr_c = par_err_q;
                        push_c = !par_err_q;
`else
                        push_c = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        // Bad stop bit: wait out any break before looking for a new start.
                        ferr_c  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO status and accepted-operation decode; a pop frees a slot for a same-cycle push.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]) &&
                     (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]);
    assign pop_c   = uart_rdreq && !empty_c;
    assign wr_en_c = push_c && (!full_c || pop_c);

    // FIFO pointer and sticky overrun next-state.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        overrun_d = overrun_q;
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push_c && full_c && !pop_c) begin
            overrun_d = 1'b1;
        end
    end

    // FIFO pointer and overrun registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
        end
    end

    // Show-ahead head byte, forced to zero while empty.
    assign uart_in      = empty_c ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign uart_empty   = empty_c;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with CLKS_PER_BIT=16, FIFO_AW=2.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       uart_rxd   = 1'b1;
    logic       uart_rdreq = 1'b0;
    logic [7:0] uart_in;
    logic       uart_empty;
    logic       rx_overrun;
    logic       rx_frame_err;

    int errors   = 0;
    int checks   = 0;
    int ferr_cnt = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_push;
    } vec_t;

    vec_t vecs [8];

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rxd    (uart_rxd),
        .uart_rdreq  (uart_rdreq),
        .uart_in     (uart_in),
        .uart_empty  (uart_empty),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    // Count frame-error pulses.
    always @(negedge clk) begin
        if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int hold);
        uart_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            idle(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = ^d;
        idle(CPB);
`endif
        uart_rxd = stop_bit;
        idle(CPB);
        idle(hold);
        uart_rxd = 1'b1;
    endtask

    task automatic read_byte(input string name);
        logic [7:0] e;
        check({name, "_not_empty"}, 32'(uart_empty), 32'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected <no byte queued>", name, uart_in);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(uart_in), 32'(e));
        end
        uart_rdreq = 1'b1;
        @(negedge clk);
        uart_rdreq = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        check("rst_empty",     32'(uart_empty),   32'd1);
        check("rst_uart_in",   32'(uart_in),      32'h00);
        check("rst_overrun",   32'(rx_overrun),   32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        rst_n = 1'b1;
        idle(2);
        exp_q.delete();
    endtask

    initial begin
        int  f0;
        bit  seen;
        logic [7:0] e;

        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h55, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1};
        vecs[6] = '{8'h7E, 1'b0, 1'b0};
        vecs[7] = '{8'hC3, 1'b1, 1'b1};

        @(negedge clk);
        do_reset();

        // Table of single frames: good and bad stop bits.
        for (int i = 0; i < 8; i++) begin
            f0 = ferr_cnt;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit, 0);
            idle(4);
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), vecs[i].exp_push ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_empty", i), 32'(uart_empty), vecs[i].exp_push ? 32'd0 : 32'd1);
            if (vecs[i].exp_push) begin
                read_byte($sformatf("vec%0d_data", i));
                idle(1);
                check($sformatf("vec%0d_empty_after_pop", i), 32'(uart_empty), 32'd1);
            end
        end

        // Pop on empty is ignored.
        uart_rdreq = 1'b1;
        idle(3);
        uart_rdreq = 1'b0;
        idle(1);
        check("pop_empty_still_empty", 32'(uart_empty), 32'd1);
        check("pop_empty_uart_in", 32'(uart_in), 32'h00);

        // Short low glitch is rejected, receiver still usable.
        f0 = ferr_cnt;
        uart_rxd = 1'b0;
        idle(4);
        uart_rxd = 1'b1;
        idle(40);
        check("glitch_empty", 32'(uart_empty), 32'd1);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 0);
        idle(4);
        read_byte("glitch_next");

        // Bad stop bit followed by a held break: a single error, then normal reception.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 40);
        idle(4);
        check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_empty", 32'(uart_empty), 32'd1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 0);
        idle(4);
        read_byte("break_next");

        // Overrun: five bytes into a four-entry FIFO.
        do_reset();
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0);
            idle(2);
        end
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        for (int b = 1; b <= 4; b++) read_byte($sformatf("ovr_pop%0d", b));
        idle(1);
        check("ovr_empty", 32'(uart_empty), 32'd1);
        check("ovr_sticky", 32'(rx_overrun), 32'd1);

        // Full FIFO: pop on the same edge as the fifth push.
        do_reset();
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0);
            idle(2);
        end
        check("full_no_ovr", 32'(rx_overrun), 32'd0);
        seen = 1'b0;
        fork
            send_frame(8'h05, 1'b1, 0);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (dut.push_c) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    e = exp_q.pop_front();
                    check("simul_head", 32'(uart_in), 32'(e));
                    uart_rdreq = 1'b1;
                    exp_q.push_back(8'h05);
                    @(negedge clk);
                    uart_rdreq = 1'b0;
                end
            end
        join
        check("simul_push_seen", 32'(seen), 32'd1);
        idle(4);
        check("simul_no_ovr", 32'(rx_overrun), 32'd0);
        for (int b = 2; b <= 5; b++) read_byte($sformatf("simul_pop%0d", b));
        idle(1);
        check("simul_empty", 32'(uart_empty), 32'd1);

        // Reset in the middle of a frame discards it.
        do_reset();
        f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                idle(CPB * 4 + CPB / 2);
                rst_n = 1'b0;
                idle(3);
                rst_n = 1'b1;
            end
        join
        idle(4);
        check("midrst_empty", 32'(uart_empty), 32'd1);
        check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("midrst_ovr", 32'(rx_overrun), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 0);
        idle(4);
        read_byte("midrst_next");
        idle(1);
        check("final_empty", 32'(uart_empty), 32'd1);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
